recovery_sequencer: RTL and testbench
=====================================

Name: recovery_sequencer

Overview:
- Controller that sequences rollback recovery for the fault-tolerant RISC-V core.
- Gates the architectural write enables (PC, register file, data memory) and requests periodic checkpoints.
- On a detected fault: drains, triggers a checkpoint restore, resumes, and escalates to a sticky fatal state after too many consecutive retries.
- Drives the pc_write / reg_write / mem_write / recovery_active signals tapped by the estimation logic.

Parameters:
- CKPT_INTERVAL, 64: retired instructions between checkpoints; power of two, >= 2.
- DRAIN_CYCLES, 4: cycles spent in DRAIN; >= 1.
- RESTORE_CYCLES, 2: cycles spent in RESTORE; >= 1.
- MAX_RETRY, 3: restores allowed without an intervening checkpoint; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fault_detected  in  1  fault flag from the comparator/checker, sampled each cycle.
- instr_commit  in  1  one instruction retired this cycle.
- pc_write_req  in  1  raw PC write enable from the core.
- reg_write_req  in  1  raw register-file write enable.
- mem_write_req  in  1  raw data-memory write enable.
- pc_write  out  1  gated PC write enable.
- reg_write  out  1  gated register-file write enable.
- mem_write  out  1  gated data-memory write enable.
- ckpt_save  out  1  one-cycle pulse: snapshot architectural state.
- ckpt_restore  out  1  one-cycle pulse: reload last checkpoint.
- recovery_active  out  1  high in every state except RUN.
- fatal_error  out  1  sticky; high in FATAL.
- retry_count  out  $clog2(MAX_RETRY+1)  restores since last checkpoint.

Behaviour:
- Reset (async, immediate, including mid-recovery):
  - state=RUN; commit counter=0; retry_count=0.
  - ckpt_save=0, ckpt_restore=0, recovery_active=0, fatal_error=0.
- States: RUN, DRAIN, RESTORE, RESUME, FATAL.
- Write gating (combinational): X_write = X_write_req & (state==RUN) & ~fault_detected. In the fault cycle itself, writes are already blocked.
- All other outputs are registered.
- RUN:
  - instr_commit increments the commit counter (width $clog2(CKPT_INTERVAL)).
  - Commit while counter==CKPT_INTERVAL-1 and no fault: counter wraps to 0, ckpt_save=1 the next cycle for exactly one cycle, retry_count clears to 0 in that same cycle.
  - fault_detected=1 at cycle T: DRAIN at T+1, recovery_active=1 from T+1.
  - Fault has priority over checkpoint completion in the same cycle: no ckpt_save, counter not advanced.
- DRAIN:
  - Held for DRAIN_CYCLES cycles.
  - On exit, if retry_count==MAX_RETRY go to FATAL.
  - Otherwise go to RESTORE; retry_count+1 and ckpt_restore=1 in the first RESTORE cycle.
- RESTORE:
  - Held for RESTORE_CYCLES cycles; commit counter cleared to 0.
  - Then RESUME.
- RESUME: one cycle, then RUN; recovery_active=0 from the first RUN cycle.
- Defaults, fault at T: DRAIN T+1..T+4, RESTORE T+5..T+6 (ckpt_restore at T+5), RESUME T+7, RUN T+8.
- Outside RUN: fault_detected and instr_commit are ignored; ckpt_save is never asserted.
- FATAL: terminal until reset; writes 0, recovery_active=1, fatal_error=1, retry_count holds MAX_RETRY.
- ckpt_save and ckpt_restore are never high in the same cycle.
- retry_count saturates at MAX_RETRY and never wraps.

Test Plan:
- Reset then 64 consecutive commits, no fault -> ckpt_save one-cycle pulse the cycle after the 64th commit; counter back to 0; write outputs track req throughout.
- Fault pulse at T with all reqs=1 -> writes 0 at T; recovery_active 1 over T+1..T+7; ckpt_restore only at T+5; retry_count=1; RUN and writes restored at T+8.
- Fault in the same cycle as the 64th commit -> no ckpt_save; DRAIN next cycle; after restore, 64 fresh commits are required for the next ckpt_save.
- Four faults with no intervening checkpoint (each injected right after RUN resumes) -> restores 1-3 occur; the fourth drain exits to FATAL with fatal_error=1 and retry_count=3; further faults and commits have no effect.
- Three faults, then 64 clean commits -> ckpt_save clears retry_count to 0; a subsequent fault recovers normally.
- Assert reset during RESTORE and during FATAL -> all outputs at reset values immediately (asynchronous); writes follow req on the first cycle after deassertion.

Source files
------------

// File: rtl/recovery_sequencer.sv
// Purpose: rollback-recovery controller; gates architectural writes, requests checkpoints, sequences restore and fatal escalation.
// Latency: write gating is combinational; state, pulse and status outputs are registered, so a fault at T shows up in recovery_active at T+1.
// Backpressure: none; the core is stalled only through the gated write enables, and nothing upstream is ever throttled.
module recovery_sequencer #(
  parameter int CKPT_INTERVAL  = 64,
  parameter int DRAIN_CYCLES   = 4,
  parameter int RESTORE_CYCLES = 2,
  parameter int MAX_RETRY      = 3,
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fault_detected,
  input  logic          instr_commit,
  input  logic          pc_write_req,
  input  logic          reg_write_req,
  input  logic          mem_write_req,
  output logic          pc_write,
  output logic          reg_write,
  output logic          mem_write,
  output logic          ckpt_save,
  output logic          ckpt_restore,
  output logic          recovery_active,
  output logic          fatal_error,
  output logic [RW-1:0] retry_count
);

  localparam int CW   = $clog2(CKPT_INTERVAL);
  localparam int PMAX = (DRAIN_CYCLES > RESTORE_CYCLES) ? DRAIN_CYCLES : RESTORE_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    RESTORE,
    RESUME,
    FATAL
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   commit_cnt;
  logic [PW-1:0]   phase_cnt;
  logic            in_run;
  logic            ckpt_hit;
  logic            enter_restore;

  assign in_run = (state == RUN);

  // A checkpoint completes only on a clean commit; a coincident fault wins.
  assign ckpt_hit = in_run & ~fault_detected & instr_commit &
                    (commit_cnt == CW'(CKPT_INTERVAL - 1));

  assign enter_restore = (state == DRAIN) & (state_next == RESTORE);

  // Writes are blocked in the fault cycle itself, before the state changes.
  assign pc_write  = pc_write_req  & in_run & ~fault_detected;
  assign reg_write = reg_write_req & in_run & ~fault_detected;
  assign mem_write = mem_write_req & in_run & ~fault_detected;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; DRAIN exits to FATAL once the retry budget is spent.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (fault_detected) state_next = DRAIN;
      end
      DRAIN: begin
        if (phase_cnt == PW'(DRAIN_CYCLES - 1)) begin
          state_next = (retry_count == RW'(MAX_RETRY)) ? FATAL : RESTORE;
        end
      end
      RESTORE: begin
        if (phase_cnt == PW'(RESTORE_CYCLES - 1)) state_next = RESUME;
      end
      RESUME:  state_next = RUN;
      FATAL:   state_next = FATAL;
      default: state_next = RUN;
    endcase
  end

  // Dwell counter for DRAIN/RESTORE; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (state_next != state) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Retired-instruction counter; wraps naturally since the interval is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_cnt <= '0;
    end else if (state == RESTORE) begin
      commit_cnt <= '0;
    end else if (in_run & ~fault_detected & instr_commit) begin
      commit_cnt <= commit_cnt + 1'b1;
    end
  end

  // Retry tracking: a checkpoint forgives past retries; each restore consumes one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_count <= '0;
    end else if (ckpt_hit) begin
      retry_count <= '0;
    end else if (enter_restore && (retry_count != RW'(MAX_RETRY))) begin
      retry_count <= retry_count + 1'b1;
    end
  end

  // Registered pulses and status flags, derived from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckpt_save       <= 1'b0;
      ckpt_restore    <= 1'b0;
      recovery_active <= 1'b0;
      fatal_error     <= 1'b0;
    end else begin
      ckpt_save       <= ckpt_hit;
      ckpt_restore    <= enter_restore;
      recovery_active <= (state_next != RUN);
      fatal_error     <= (state_next == FATAL);
    end
  end

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed bench for recovery_sequencer: stimulus pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
// Output vector order: {pc_write, reg_write, mem_write, ckpt_save, ckpt_restore, recovery_active, fatal_error, retry_count[1:0]}.
module tb_recovery_sequencer;

  logic       clk;
  logic       reset;
  logic       fault_detected;
  logic       instr_commit;
  logic       pc_write_req;
  logic       reg_write_req;
  logic       mem_write_req;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       ckpt_save;
  logic       ckpt_restore;
  logic       recovery_active;
  logic       fatal_error;
  logic [1:0] retry_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      lbl_q[$];

  recovery_sequencer #(
    .CKPT_INTERVAL (64),
    .DRAIN_CYCLES  (4),
    .RESTORE_CYCLES(2),
    .MAX_RETRY     (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fault_detected (fault_detected),
    .instr_commit   (instr_commit),
    .pc_write_req   (pc_write_req),
    .reg_write_req  (reg_write_req),
    .mem_write_req  (mem_write_req),
    .pc_write       (pc_write),
    .reg_write      (reg_write),
    .mem_write      (mem_write),
    .ckpt_save      (ckpt_save),
    .ckpt_restore   (ckpt_restore),
    .recovery_active(recovery_active),
    .fatal_error    (fatal_error),
    .retry_count    (retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input logic [2:0] w, input logic s, input logic r,
                                     input logic a, input logic f, input logic [1:0] rc);
    return {w, s, r, a, f, rc};
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what the DUT must show.
  task automatic step(input logic rst, input logic f, input logic c, input logic [2:0] req,
                      input logic [8:0] e, input string nm);
    @(posedge clk);
    #1;
    reset          = rst;
    fault_detected = f;
    instr_commit   = c;
    pc_write_req   = req[2];
    reg_write_req  = req[1];
    mem_write_req  = req[0];
    exp_q.push_back(e);
    lbl_q.push_back(nm);
  endtask

  // Full recovery from RUN: fault at T, drain T+1..T+4, restore T+5..T+6, resume T+7, run T+8.
  task automatic recover(input logic [1:0] rc0, input logic commit_at_fault, input string nm);
    logic [1:0] rc1;
    rc1 = rc0 + 2'd1;
    step(0, 1, commit_at_fault, 3'b111, ex(3'b000, 0, 0, 0, 0, rc0), {nm, " fault"});
    for (int k = 1; k <= 4; k++)
      step(0, (k == 2), 1, 3'b111, ex(3'b000, 0, 0, 1, 0, rc0), $sformatf("%s drain%0d", nm, k));
    step(0, 0, 1, 3'b111, ex(3'b000, 0, 1, 1, 0, rc1), {nm, " restore1"});
    step(0, 0, 1, 3'b111, ex(3'b000, 0, 0, 1, 0, rc1), {nm, " restore2"});
    step(0, 0, 1, 3'b111, ex(3'b000, 0, 0, 1, 0, rc1), {nm, " resume"});
    step(0, 0, 0, 3'b111, ex(3'b111, 0, 0, 0, 0, rc1), {nm, " run"});
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] act;
      logic [8:0] e;
      string      nm;
      act = {pc_write, reg_write, mem_write, ckpt_save, ckpt_restore,
             recovery_active, fatal_error, retry_count};
      e  = exp_q.pop_front();
      nm = lbl_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    fault_detected = 1'b0;
    instr_commit   = 1'b0;
    pc_write_req   = 1'b0;
    reg_write_req  = 1'b0;
    mem_write_req  = 1'b0;

    // Reset state, then release.
    step(1, 0, 0, 3'b000, ex(3'b000, 0, 0, 0, 0, 2'd0), "reset");
    step(0, 0, 0, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd0), "release");

    // 64 commits with varying write requests; pulse the cycle after the 64th.
    for (int i = 0; i < 64; i++) begin
      logic [2:0] rq;
      rq = 3'(i);
      step(0, 0, 1, rq, ex(rq, 0, 0, 0, 0, 2'd0), $sformatf("commit%0d", i));
    end
    step(0, 0, 0, 3'b111, ex(3'b111, 1, 0, 0, 0, 2'd0), "ckpt pulse");
    step(0, 0, 0, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd0), "ckpt pulse end");

    // Single fault recovery.
    recover(2'd0, 0, "rec1");

    // Fault coinciding with the 64th commit.
    for (int i = 0; i < 63; i++)
      step(0, 0, 1, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd1), $sformatf("pre%0d", i));
    recover(2'd1, 1, "rec64");
    for (int i = 0; i < 63; i++)
      step(0, 0, 1, 3'b101, ex(3'b101, 0, 0, 0, 0, 2'd2), $sformatf("fresh%0d", i));
    step(0, 0, 0, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd2), "no ckpt at 63");
    step(0, 0, 1, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd2), "fresh commit64");
    step(0, 0, 0, 3'b111, ex(3'b111, 1, 0, 0, 0, 2'd0), "fresh ckpt clears retry");

    // Escalation to FATAL.
    recover(2'd0, 0, "esc1");
    recover(2'd1, 0, "esc2");
    recover(2'd2, 0, "esc3");
    step(0, 1, 0, 3'b111, ex(3'b000, 0, 0, 0, 0, 2'd3), "esc4 fault");
    for (int k = 1; k <= 4; k++)
      step(0, 0, 0, 3'b111, ex(3'b000, 0, 0, 1, 0, 2'd3), $sformatf("esc4 drain%0d", k));
    for (int k = 0; k < 70; k++)
      step(0, (k % 5 == 0), 1, 3'b111, ex(3'b000, 0, 0, 1, 1, 2'd3), $sformatf("fatal%0d", k));

    // Reset during FATAL takes effect immediately.
    step(1, 0, 0, 3'b000, ex(3'b000, 0, 0, 0, 0, 2'd0), "reset in fatal");
    step(0, 0, 0, 3'b101, ex(3'b101, 0, 0, 0, 0, 2'd0), "after fatal reset");

    // Three faults, then a checkpoint forgives them.
    recover(2'd0, 0, "f1");
    recover(2'd1, 0, "f2");
    recover(2'd2, 0, "f3");
    for (int i = 0; i < 64; i++)
      step(0, 0, 1, 3'b111, ex(3'b111, 0, 0, 0, 0, 2'd3), $sformatf("clean%0d", i));
    step(0, 0, 0, 3'b111, ex(3'b111, 1, 0, 0, 0, 2'd0), "clean ckpt");
    recover(2'd0, 0, "post ckpt");

    // Reset asserted in the first RESTORE cycle.
    step(0, 1, 0, 3'b111, ex(3'b000, 0, 0, 0, 0, 2'd1), "rst-rec fault");
    for (int k = 1; k <= 4; k++)
      step(0, 0, 0, 3'b111, ex(3'b000, 0, 0, 1, 0, 2'd1), $sformatf("rst-rec drain%0d", k));
    step(1, 0, 0, 3'b000, ex(3'b000, 0, 0, 0, 0, 2'd0), "reset in restore");
    step(0, 0, 0, 3'b011, ex(3'b011, 0, 0, 0, 0, 2'd0), "after restore reset");
    recover(2'd0, 0, "after reset rec");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
